// File: rtl/xfade_matrix.sv
// Time-multiplexed N_IN x N_OUT routing matrix with click-free linear crossfade on select changes.
// Optional per-sink Q1.7 output gain stage is enabled by defining XFADE_MATRIX_GAIN_EN.
module xfade_matrix #(
    parameter int BITSIZE   = 16,
    parameter int N_IN      = 16,
    parameter int N_OUT     = 12,
    parameter int SELSIZE   = 4,
    parameter int RAMP_BITS = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sample_strobe,
    input  logic [N_IN*BITSIZE-1:0]    in_bus,
    input  logic [N_OUT*SELSIZE-1:0]   sel_bus,
`ifdef XFADE_MATRIX_GAIN_EN
    input  logic [N_OUT*8-1:0]         gain_bus,
`endif
    output logic [N_OUT*BITSIZE-1:0]   out_bus,
    output logic                       busy,
    output logic                       overrun
);

    localparam int SLOT_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int K_W    = RAMP_BITS + 1;
    localparam int P_W    = BITSIZE + RAMP_BITS + 3;
    localparam logic [K_W-1:0] K_FULL = {1'b1, {RAMP_BITS{1'b0}}};
`ifdef XFADE_MATRIX_GAIN_EN
    localparam int N_DRAIN = 3;
    localparam int G_W     = BITSIZE + 9;
`else
    localparam int N_DRAIN = 2;
`endif

    typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_PROC, S_DRAIN, S_COMMIT} state_t;

    state_t                     r_state;
    logic [SLOT_W-1:0]          r_slot;
    logic [1:0]                 r_drain;
    logic                       r_busy;
    logic                       r_overrun;
    logic [N_OUT*BITSIZE-1:0]   r_out;
    logic signed [BITSIZE-1:0]  r_snap [N_IN];
    logic [SELSIZE-1:0]         r_sel  [N_OUT];
    logic [SELSIZE-1:0]         r_cur  [N_OUT];
    logic [SELSIZE-1:0]         r_prev [N_OUT];
    logic [K_W-1:0]             r_k    [N_OUT];
    logic signed [BITSIZE-1:0]  r_res  [N_OUT];
`ifdef XFADE_MATRIX_GAIN_EN
    logic [7:0]                 r_gain [N_OUT];
`endif

    logic [SELSIZE-1:0]         w_sel, w_cur, w_prev, w_cur_n, w_prev_n;
    logic [K_W-1:0]             w_k, w_k_n;
    logic                       w_start;
    logic signed [BITSIZE-1:0]  w_a, w_b;
    logic signed [BITSIZE:0]    w_d;
    logic signed [P_W-1:0]      w_p;

    // Ramp decision for the sink in the current slot; the sample uses the post-update state.
    always_comb begin
        w_sel    = r_sel[r_slot];
        w_cur    = r_cur[r_slot];
        w_prev   = r_prev[r_slot];
        w_k      = r_k[r_slot];
        w_start  = (w_k == K_FULL) && (w_sel != w_cur);
        w_cur_n  = w_start ? w_sel : w_cur;
        w_prev_n = w_start ? w_cur : w_prev;
        if (w_start)
            w_k_n = '0;
        else if (w_k != K_FULL)
            w_k_n = w_k + 1'b1;
        else
            w_k_n = w_k;
        w_a = '0;
        w_b = '0;
        if (int'(w_prev_n) < N_IN)
            w_a = r_snap[w_prev_n];
        if (int'(w_cur_n) < N_IN)
            w_b = r_snap[w_cur_n];
        w_d = {w_b[BITSIZE-1], w_b} - {w_a[BITSIZE-1], w_a};
        w_p = P_W'(w_d) * P_W'($signed({1'b0, w_k_n}));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_slot    <= '0;
            r_drain   <= '0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
            r_out     <= '0;
            for (int unsigned i = 0; i < N_IN; i++)
                r_snap[i] <= '0;
            for (int unsigned j = 0; j < N_OUT; j++) begin
                r_sel[j]  <= '1;
                r_cur[j]  <= '1;
                r_prev[j] <= '1;
                r_k[j]    <= K_FULL;
`ifdef XFADE_MATRIX_GAIN_EN
                r_gain[j] <= '0;
`endif
            end
        end else begin
            if (sample_strobe && (r_state != S_IDLE))
                r_overrun <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (sample_strobe) begin
                        r_state <= S_CAPTURE;
                        r_busy  <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    for (int unsigned i = 0; i < N_IN; i++)
                        r_snap[i] <= in_bus[i*BITSIZE +: BITSIZE];
                    for (int unsigned j = 0; j < N_OUT; j++) begin
                        r_sel[j] <= sel_bus[j*SELSIZE +: SELSIZE];
`ifdef XFADE_MATRIX_GAIN_EN
                        r_gain[j] <= gain_bus[j*8 +: 8];
`endif
                    end
                    r_slot  <= '0;
                    r_state <= S_PROC;
                end
                S_PROC: begin
                    r_cur[r_slot]  <= w_cur_n;
                    r_prev[r_slot] <= w_prev_n;
                    r_k[r_slot]    <= w_k_n;
                    if (r_slot == SLOT_W'(N_OUT - 1)) begin
                        r_drain <= '0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_slot <= r_slot + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (r_drain == 2'(N_DRAIN - 1))
                        r_state <= S_COMMIT;
                    else
                        r_drain <= r_drain + 1'b1;
                end
                S_COMMIT: begin
                    for (int unsigned j = 0; j < N_OUT; j++)
                        r_out[j*BITSIZE +: BITSIZE] <= r_res[j];
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    logic                       r_v1;
    logic [SLOT_W-1:0]          r_i1;
    logic signed [BITSIZE-1:0]  r_a1;
    logic signed [P_W-1:0]      r_p1;
    logic signed [P_W-1:0]      w_sum;
    logic signed [BITSIZE-1:0]  w_y;
`ifdef XFADE_MATRIX_GAIN_EN
    logic [7:0]                 r_g1, r_g2;
    logic                       r_v2;
    logic [SLOT_W-1:0]          r_i2;
    logic signed [BITSIZE-1:0]  r_y2;
    logic signed [G_W-1:0]      w_gp, w_gs;
    logic signed [BITSIZE-1:0]  w_z;
`endif

    always_comb begin
        w_sum = P_W'(r_a1) + (r_p1 >>> RAMP_BITS);
        w_y   = w_sum[BITSIZE-1:0];
`ifdef XFADE_MATRIX_GAIN_EN
        w_gp = G_W'(r_y2) * G_W'($signed({1'b0, r_g2}));
        w_gs = w_gp >>> 7;
        // In range only when every bit above the result's sign bit matches it.
        if ((w_gs[G_W-1:BITSIZE-1] == '0) || (w_gs[G_W-1:BITSIZE-1] == '1))
            w_z = w_gs[BITSIZE-1:0];
        else if (w_gs[G_W-1])
            w_z = {1'b1, {(BITSIZE-1){1'b0}}};
        else
            w_z = {1'b0, {(BITSIZE-1){1'b1}}};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_i1 <= '0;
            r_a1 <= '0;
            r_p1 <= '0;
            for (int unsigned j = 0; j < N_OUT; j++)
                r_res[j] <= '0;
`ifdef XFADE_MATRIX_GAIN_EN
            r_g1 <= '0;
            r_g2 <= '0;
            r_v2 <= 1'b0;
            r_i2 <= '0;
            r_y2 <= '0;
`endif
        end else begin
            r_v1 <= (r_state == S_PROC);
            r_i1 <= r_slot;
            r_a1 <= w_a;
            r_p1 <= w_p;
`ifdef XFADE_MATRIX_GAIN_EN
            r_g1 <= r_gain[r_slot];
            r_v2 <= r_v1;
            r_i2 <= r_i1;
            r_y2 <= w_y;
            r_g2 <= r_g1;
            if (r_v2)
                r_res[r_i2] <= w_z;
`else
            if (r_v1)
                r_res[r_i1] <= w_y;
`endif
        end
    end

    assign out_bus = r_out;
    assign busy    = r_busy;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_xfade_matrix.sv
// Directed self-checking bench for xfade_matrix: reset, routing ramp, signed crossfade,
// held mid-ramp changes, overrun, mid-sweep reset, and gain when XFADE_MATRIX_GAIN_EN is defined.
module tb_xfade_matrix;

    localparam int BS = 16;
    localparam int NI = 15;   // leaves select value 15 as mute
    localparam int NO = 12;
    localparam int SS = 4;
    localparam int RB = 6;
    localparam int OW = NO * BS;
`ifdef XFADE_MATRIX_GAIN_EN
    localparam int LAT = NO + 5;
`else
    localparam int LAT = NO + 4;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              strobe;
    logic [NI*BS-1:0]  in_bus;
    logic [NO*SS-1:0]  sel_bus;
    logic [OW-1:0]     out_bus;
    logic              busy;
    logic              overrun;
`ifdef XFADE_MATRIX_GAIN_EN
    logic [NO*8-1:0]   gain_bus;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    xfade_matrix #(
        .BITSIZE   (BS),
        .N_IN      (NI),
        .N_OUT     (NO),
        .SELSIZE   (SS),
        .RAMP_BITS (RB)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sample_strobe (strobe),
        .in_bus        (in_bus),
        .sel_bus       (sel_bus),
`ifdef XFADE_MATRIX_GAIN_EN
        .gain_bus      (gain_bus),
`endif
        .out_bus       (out_bus),
        .busy          (busy),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [OW-1:0] s0(input logic [BS-1:0] v);
        logic [OW-1:0] r;
        r = '0;
        r[BS-1:0] = v;
        return r;
    endfunction

    // One sweep: strobe, count cycles until busy drops, keep out_bus from the cycle before commit.
    task automatic sample(output int lat, output logic [OW-1:0] pre);
        @(negedge clk) strobe = 1'b1;
        @(posedge clk);
        #1 strobe = 1'b0;
        lat = 0;
        pre = '0;
        while (busy && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == LAT - 1)
                pre = out_bus;
        end
    endtask

    int            lat;
    int            falls;
    logic          prevb;
    logic [OW-1:0] pre;
    logic [BS-1:0] ev;
    logic signed [BS-1:0] v, pv;

    initial begin
        rst_n   = 1'b0;
        strobe  = 1'b0;
        in_bus  = {NI{16'h4000}};
        sel_bus = {NO{4'hF}};
`ifdef XFADE_MATRIX_GAIN_EN
        gain_bus = {NO{8'h80}};
`endif
        // Reset hold with strobes applied
        repeat (3) begin
            @(negedge clk) strobe = 1'b1;
            @(negedge clk) strobe = 1'b0;
        end
        repeat (20) @(negedge clk);
        chk("rst_out", out_bus, '0);
        chk("rst_busy", OW'(busy), OW'(0));
        chk("rst_ovr", OW'(overrun), OW'(0));
        @(negedge clk) rst_n = 1'b1;
        repeat (2) begin
            sample(lat, pre);
            chk("mute_lat", OW'(lat), OW'(LAT));
            chk("mute_out", out_bus, '0);
        end

        // Basic route: mute -> source 0
        in_bus = '0;
        in_bus[0 +: BS] = 16'h1000;
        sel_bus[0 +: SS] = 4'd0;
        for (int n = 0; n <= 65; n++) begin
            sample(lat, pre);
            chk("route_lat", OW'(lat), OW'(LAT));
            ev = (n <= 64) ? BS'(64 * n) : 16'h1000;
            chk("route_out", out_bus, s0(ev));
            if (n == 1)
                chk("route_pre", pre, '0);
        end

        // Crossfade full-scale positive to full-scale negative
        in_bus[0 +: BS]  = 16'h7FFF;
        in_bus[BS +: BS] = 16'h8000;
        sample(lat, pre);
        chk("xf_settled", out_bus, s0(16'h7FFF));
        sel_bus[0 +: SS] = 4'd1;
        pv = 16'sh7FFF;
        for (int n = 0; n <= 64; n++) begin
            sample(lat, pre);
            v = out_bus[BS-1:0];
            if (n == 0)  chk("xf_s0",  out_bus, s0(16'h7FFF));
            if (n == 32) chk("xf_s32", out_bus, s0(16'hFFFF));
            if (n == 64) chk("xf_s64", out_bus, s0(16'h8000));
            if (n > 0)   chk("xf_mono", OW'(v < pv), OW'(1));
            pv = v;
        end

        // Mid-ramp change held until the running ramp completes
        in_bus[0 +: BS]    = 16'h0000;
        in_bus[BS +: BS]   = 16'h1000;
        in_bus[2*BS +: BS] = 16'h3000;
        sel_bus[0 +: SS] = 4'd0;
        repeat (65) sample(lat, pre);
        chk("mid_settle", out_bus, s0(16'h0000));
        sel_bus[0 +: SS] = 4'd1;
        for (int n = 0; n <= 130; n++) begin
            if (n == 10) sel_bus[0 +: SS] = 4'd2;
            sample(lat, pre);
            if (n <= 64)
                ev = BS'(64 * n);
            else if (n - 65 >= 64)
                ev = 16'h3000;
            else
                ev = BS'(16'h1000 + 128 * (n - 65));
            chk("mid_ramp", out_bus, s0(ev));
        end
        // Change and change back while ramping: only one ramp
        sel_bus[0 +: SS] = 4'd1;
        for (int n = 0; n <= 66; n++) begin
            if (n == 10) sel_bus[0 +: SS] = 4'd2;
            if (n == 20) sel_bus[0 +: SS] = 4'd1;
            sample(lat, pre);
            ev = (n <= 64) ? BS'(16'h3000 - 128 * n) : 16'h1000;
            chk("mid_back", out_bus, s0(ev));
        end

`ifdef XFADE_MATRIX_GAIN_EN
        in_bus[BS +: BS] = 16'h6000;
        gain_bus[0 +: 8] = 8'hFF;
        sample(lat, pre);
        chk("gain_sat", out_bus, s0(16'h7FFF));
        gain_bus[0 +: 8] = 8'h40;
        sample(lat, pre);
        chk("gain_lat", OW'(lat), OW'(17));
        chk("gain_half", out_bus, s0(16'h3000));
        gain_bus[0 +: 8] = 8'h80;
`endif

        // Overrun: second strobe 5 cycles after the first
        chk("ovr_pre", OW'(overrun), OW'(0));
        @(negedge clk) strobe = 1'b1;
        @(negedge clk) strobe = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk) strobe = 1'b1;
        @(negedge clk) strobe = 1'b0;
        falls = 0;
        prevb = busy;
        repeat (60) begin
            @(negedge clk);
            if (prevb && !busy) falls++;
            prevb = busy;
        end
        chk("ovr_commits", OW'(falls), OW'(1));
        chk("ovr_flag", OW'(overrun), OW'(1));
        sample(lat, pre);
        chk("ovr_sticky", OW'(overrun), OW'(1));
        chk("ovr_lat", OW'(lat), OW'(LAT));

        // Reset during PROC slot 3
        @(negedge clk) strobe = 1'b1;
        @(posedge clk);
        #1 strobe = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_out", out_bus, '0);
        chk("mrst_busy", OW'(busy), OW'(0));
        chk("mrst_ovr", OW'(overrun), OW'(0));
        @(negedge clk) rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("mrst_nocommit", out_bus, '0);
        chk("mrst_idle", OW'(busy), OW'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/xfade_matrix.md
Name: xfade_matrix

Overview:
- Parametrised successor to the fixed 10x11 routing matrix: N_IN sources are routed to N_OUT sinks, one select field per sink.
- A select change does not switch hard. The sink crossfades linearly from the old source to the new one over 2^RAMP_BITS samples, which removes clicks when patches change at runtime.
- Sinks are processed time-multiplexed on the system clock, using one shared multiply datapath per sample period.
- The block sits between the generator/effect outputs and the mixer/effect/I2S inputs. CPU parameter registers drive sel_bus.

Parameters:
- BITSIZE, 16, sample width (signed, two's complement).
- N_IN, 16, number of source channels.
- N_OUT, 12, number of sink channels.
- SELSIZE, 4, select field width; select values >= N_IN mean mute (output 0).
- RAMP_BITS, 6, crossfade length is 2^RAMP_BITS samples (64 = 1.33 ms at 48 kHz).

Ports:
- clk, input, 1, system clock (49.152 MHz OSC).
- rst_n, input, 1, asynchronous active-low reset.
- sample_strobe, input, 1, one-cycle pulse per sample period, synchronous to clk.
- in_bus, input, N_IN*BITSIZE, source i occupies [i*BITSIZE +: BITSIZE].
- sel_bus, input, N_OUT*SELSIZE, select for sink j occupies [j*SELSIZE +: SELSIZE].
- out_bus, output, N_OUT*BITSIZE, sink j occupies [j*BITSIZE +: BITSIZE].
- busy, output, 1, high while a sweep is in progress.
- overrun, output, 1, sticky; set when a strobe arrives while busy.

Behaviour:
- Reset values:
  - out_bus = 0, busy = 0, overrun = 0.
  - Per-sink cur_sel = prev_sel = all-ones (mute), k = 2^RAMP_BITS (ramp idle).
  - Input snapshot = 0.
- FSM states: IDLE, CAPTURE, PROC, DRAIN, COMMIT.
  - IDLE: on sample_strobe, go to CAPTURE and set busy = 1.
  - CAPTURE (1 cycle): register in_bus into the snapshot and register sel_bus. Later changes to in_bus or sel_bus do not affect this sweep.
  - PROC: N_OUT cycles. Slot j = 0..N_OUT-1 issues sink j into a 2-stage pipeline (multiply, then add/shift).
  - DRAIN: 2 cycles to flush the pipeline.
  - COMMIT (1 cycle): all sink results are copied to out_bus together, busy = 0, return to IDLE.
- Latency:
  - out_bus changes exactly N_OUT+4 clk cycles after the strobe cycle.
  - All sinks update in the same cycle; no partial updates are visible.
- Per-sink ramp control, evaluated in sink j's PROC slot:
  - If k == 2^R and the captured sel != cur_sel: prev_sel <= cur_sel, cur_sel <= sel, k <= 0.
  - Else if k < 2^R: k <= k+1.
  - A sel change while a ramp is running is held. It is taken at the first slot where k == 2^R, provided it still differs from cur_sel.
  - Writing back the same value never starts a ramp.
- Mix arithmetic:
  - a = src(prev_sel), b = src(cur_sel); src(x) = 0 when x >= N_IN.
  - d = b - a, computed at BITSIZE+1 bits signed.
  - p = d * k, with k unsigned at RAMP_BITS+1 bits.
  - y = a + (p >>> RAMP_BITS), arithmetic shift (floor).
  - y is a convex combination and never overflows BITSIZE.
  - k == 0 gives y = a exactly; k == 2^R gives y = b exactly.
- Ramp timing: the sample computed in the slot that starts a ramp uses k = 0. Full switchover is reached on the 2^R-th sample after the change.
- sample_strobe while busy: ignored, and overrun is set (cleared only by rst_n).
- Throughput: N_OUT+5 cycles per sweep. 1024 clk cycles are available per sample at 48 kHz.
- Reset mid-sweep: everything returns to reset values at once. No partial commit reaches out_bus.

Optional Feature:
XFADE_MATRIX_GAIN_EN
- Defined:
  - Adds input gain_bus, N_OUT*8, unsigned Q1.7 per sink (0x80 = unity, max 0xFF = 1.992).
  - A third pipeline stage computes z = (y*gain) >>> 7, saturated to the signed BITSIZE range.
  - The gain snapshot is taken in CAPTURE. Latency becomes N_OUT+5.
- Undefined: the gain_bus port does not exist, there is no third stage, and the output equals y.

Test Plan:
- Reset hold:
  - Stimulus: rst_n = 0, apply strobes, in_bus all 0x4000.
  - Required: out_bus = 0, busy = 0, overrun = 0.
  - Stimulus: release reset and issue strobes with sel = mute.
  - Required: out stays 0.
- Basic route:
  - Stimulus: in0 = 0x1000, sel0 changed from mute to 0.
  - Required: sink0 ramps 0 → 0x1000, reaching 0x0040*n at sample n, and equals exactly 0x1000 from sample 64 onward.
  - Required: each update lands N_OUT+4 = 16 cycles after its strobe.
- Crossfade with negatives:
  - Stimulus: in0 = 0x7FFF, in1 = 0x8000, sel switched from 0 to 1 after the ramp has settled.
  - Required: outputs are monotonic decreasing, never wrap, sample 32 = 0xFFFF (floor), and sample 64 = 0x8000.
- Mid-ramp change:
  - Stimulus: switch 0→1, then write sel = 2 at sample 10.
  - Required: the 0→1 ramp completes at sample 64.
  - Required: the next slot starts a 1→2 ramp with k = 0.
  - Stimulus: same, but write 2 then back to 1 before sample 64.
  - Required: no second ramp.
- Overrun:
  - Stimulus: pulse sample_strobe again 5 cycles after the first.
  - Required: the second pulse is ignored, one commit only, and overrun = 1 stays high until rst_n.
  - Stimulus: assert rst_n at PROC slot 3.
  - Required: out_bus = 0 immediately, no commit.
- Gain (with XFADE_MATRIX_GAIN_EN):
  - Stimulus: y = 0x6000, gain 0xFF.
  - Required: output saturates to 0x7FFF.
  - Stimulus: gain 0x40.
  - Required: output 0x3000, latency 17 cycles.
